regfifo_shift: RTL
==================

# regfifo_shift

Parametrised register-based shift FIFO: the successor to the fixed 17-bit × 8 register FIFO in the DMA packet path. Width, depth and almost-full/almost-empty thresholds are set by parameters. It adds an occupancy count, a synchronous flush, and sticky overflow/underflow error flags. It corrects simultaneous read/write handling on an empty FIFO. The head entry is always presented on `dout` (first-word-fall-through), so the DMA and packet engines can pop descriptors without a read-latency cycle.

## Interface
- `WIDTH`, 17: data width in bits, ≥1.
- `DEPTH`, 8: number of entries, ≥2.
- `AFULL_TH`, DEPTH-2: `almost_full` asserts when count ≥ AFULL_TH; legal range 1..DEPTH.
- `AEMPTY_TH`, 1: `almost_empty` asserts when count ≤ AEMPTY_TH; legal range 0..DEPTH-1.
- `CW`, derived as $clog2(DEPTH+1): count width (localparam).

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `flush` in 1: synchronous clear of contents; does not clear error flags.
- `wr_en` in 1: push `din` this cycle.
- `din` in WIDTH: write data.
- `rd_en` in 1: pop head entry this cycle.
- `dout` out WIDTH: head entry (entry 0); 0 when empty.
- `full` out 1: count == DEPTH.
- `empty` out 1: count == 0.
- `almost_full` out 1: count ≥ AFULL_TH.
- `almost_empty` out 1: count ≤ AEMPTY_TH.
- `count` out CW: number of valid entries, 0..DEPTH.
- `err_clr` in 1: clears `overflow` and `underflow`.
- `overflow` out 1: sticky; a write was dropped.
- `underflow` out 1: sticky; a read was ignored.

## Operation
- Storage is DEPTH registers `entry[0..DEPTH-1]`. Entry 0 is the head and drives `dout`. The occupancy register is `count`.
- Invariant: entries at index ≥ count hold 0.
- Effective strobes:
  - wr_ok = wr_en & (~full | rd_en)
  - rd_ok = rd_en & ~empty
- Priority: `rst_n`=0 > `flush` > normal operation.
- Reset / flush: all entries ← 0 and count ← 0.
  - Reset also clears `overflow` and `underflow`.
  - Flush leaves the error flags unchanged.
  - wr_en/rd_en are ignored in a flush cycle, and no error flag is set in that cycle.
- wr_ok only: entry[count] ← din; count+1.
- rd_ok only: entry[i] ← entry[i+1] for i < DEPTH-1; entry[DEPTH-1] ← 0; count−1.
- wr_ok & rd_ok (count ≥ 1): shift as for a read and write din into entry[count-1]; count unchanged. This includes the full case, where din lands in entry[DEPTH-1].
- wr_en & rd_en with count == 0: rd is ignored (underflow set), din is written to entry[0], and count becomes 1.
- wr_en & full & ~rd_en: din is dropped, overflow ← 1, state unchanged.
- rd_en & empty: underflow ← 1, state unchanged.
- `err_clr` clears both flags. If an error event occurs in the same cycle, set wins (flag ends at 1).
- Status outputs (`full`, `empty`, `almost_*`) are decoded combinationally from the `count` register only. There is no combinational path from any input to any output.

## Timing
- Reset values:
  - dout = 0, count = 0
  - empty = 1, full = 0
  - almost_empty = 1 (AEMPTY_TH ≥ 0)
  - almost_full = 0
  - overflow = 0, underflow = 0
- Write latency: a write in cycle N to an empty FIFO appears on `dout` in cycle N+1.
- Read: `dout` shows the current head in cycle N. When rd_en is high in cycle N, the next entry (or 0) appears in cycle N+1.
- `count` and all flags update one cycle after the causing strobe.
- Sustained wr_en & rd_en at any count in 1..DEPTH gives 1 push and 1 pop per cycle indefinitely, with no bubbles.
- Reset or flush in the middle of a stream takes effect at the next edge. Operations in that cycle are discarded.

## Test plan
- Reset and fill:
  - Stimulus: rst_n low for 2 cycles; then write 0x00001..0x00008 on consecutive cycles (WIDTH=17, DEPTH=8, AFULL_TH=6).
  - Required response: after reset, empty=1 and dout=0. almost_full rises the cycle after the 6th write. After the 8th write, full=1 and count=8. dout=0x00001 throughout the fill.
- Drain order:
  - Stimulus: from full, hold rd_en for 8 cycles.
  - Required response: dout sequence 0x00001..0x00008, then 0. empty=1 and count=0 after the last read. underflow stays 0.
- Simultaneous read/write on full and on empty:
  - Stimulus (full): wr_en & rd_en with din=0x1FFFF.
  - Required response (full): count stays 8, entry 7 = 0x1FFFF, overflow=0.
  - Stimulus (empty): wr_en & rd_en with din=0x0ABCD.
  - Required response (empty): count=1, dout=0x0ABCD, underflow=1.
- Error flags:
  - Stimulus: write when full without rd_en.
  - Required response: overflow=1, contents unchanged.
  - Stimulus: err_clr together with another dropped write.
  - Required response: overflow stays 1.
  - Stimulus: err_clr alone.
  - Required response: overflow cleared.
- Flush mid-stream:
  - Stimulus: with count=5 and overflow=1, assert flush together with wr_en.
  - Required response: next cycle count=0, dout=0, empty=1, overflow still 1, and the write is discarded.
- Parameter sweep:
  - Stimulus: instantiate WIDTH=64, DEPTH=2, AFULL_TH=2, AEMPTY_TH=0 and run random push/pop against a scoreboard for 10k cycles.
  - Required response: no mismatch, count ∈ 0..2, and the flags are consistent with count every cycle.

Source files
------------

// File: rtl/regfifo_shift_if.sv
// regfifo_shift_if: handshake, data and status bundle for the register shift FIFO
interface regfifo_shift_if #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);
    logic             flush;
    logic             wr_en;
    logic [WIDTH-1:0] din;
    logic             rd_en;
    logic             err_clr;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, wr_en, din, rd_en, err_clr,
        input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, din, rd_en, err_clr,
        output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/regfifo_shift.sv
// regfifo_shift: parametrised register shift FIFO with first-word-fall-through head
module regfifo_shift #(
    parameter int WIDTH     = 17,
    parameter int DEPTH     = 8,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 1
) (
    input logic            clk,
    input logic            rst_n,
    regfifo_shift_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] entry [DEPTH];
    logic [CW-1:0]    count;
    logic [AW-1:0]    wr_idx;
    logic             overflow;
    logic             underflow;
    logic             full;
    logic             empty;
    logic             wr_ok;
    logic             rd_ok;

    assign full   = count == CW'(DEPTH);
    assign empty  = count == '0;
    assign wr_ok  = bus.wr_en & (~full | bus.rd_en);
    assign rd_ok  = bus.rd_en & ~empty;
    // With a concurrent pop the tail moves down one slot, so the new word lands at count-1
    assign wr_idx = AW'(rd_ok ? count - CW'(1) : count);

    assign bus.dout         = entry[0];
    assign bus.count        = count;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = count >= CW'(AFULL_TH);
    assign bus.almost_empty = count <= CW'(AEMPTY_TH);
    assign bus.overflow     = overflow;
    assign bus.underflow    = underflow;

    // Storage shift/append, occupancy and sticky error flags; a flush cycle raises no error
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow & ~bus.err_clr) | (~bus.flush & bus.wr_en & full & ~bus.rd_en);
            underflow <= (underflow & ~bus.err_clr) | (~bus.flush & bus.rd_en & empty);
            if (bus.flush) begin
                for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
                count <= '0;
            end else begin
                if (rd_ok) begin
                    for (int i = 0; i < DEPTH - 1; i++) entry[i] <= entry[i+1];
                    entry[DEPTH-1] <= '0;
                end
                if (wr_ok) entry[wr_idx] <= bus.din;
                count <= count + CW'(wr_ok) - CW'(rd_ok);
            end
        end
    end
endmodule
